// File: rtl/ifq_pkg.sv
// Shared widths, defaults and the queue entry layout for the instruction fetch queue.
package ifq_pkg;
  localparam int          WL            = 32;
  localparam int          DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR     = 32'h0;

  typedef struct packed {
    logic [WL-1:0] instr;
    logic [WL-1:0] pcp1;
  } ifq_entry_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: redirect, instruction memory handshake and decode-side head.
interface ifetch_queue_if;
  import ifq_pkg::*;
  logic          redirect;
  logic [WL-1:0] redirect_pc;
  logic          im_req;
  logic [WL-1:0] im_addr;
  logic          im_gnt;
  logic          im_rvalid;
  logic [WL-1:0] im_rdata;
  logic          instr_valid;
  logic [WL-1:0] instr;
  logic [WL-1:0] pcp1;
  logic          dec_ready;

  modport master (
    input  redirect, redirect_pc, im_gnt, im_rvalid, im_rdata, dec_ready,
    output im_req, im_addr, instr_valid, instr, pcp1
  );
  modport slave (
    output redirect, redirect_pc, im_gnt, im_rvalid, im_rdata, dec_ready,
    input  im_req, im_addr, instr_valid, instr, pcp1
  );
endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {instr, pcp1} entries with synchronous clear.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  ifq_entry_t             wdata_i,
  input  logic                   pop_i,
  output ifq_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            full;

  assign full = (count_q == CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (clr_i)
    !(push_i && !pop_i && full));
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a small prefetch queue and redirect flush.
// Optional IFETCH_QUEUE_PERF_EN adds saturating fetched/flushed counters.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int            DEPTH    = DEPTH_DEFAULT,
  parameter logic [WL-1:0] RESET_PC = 32'h0
) (
  input  logic            CLK,
  input  logic            RST,
  ifetch_queue_if.master  bus
`ifdef IFETCH_QUEUE_PERF_EN
  ,
  output logic [WL-1:0]   perf_fetched,
  output logic [WL-1:0]   perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WL-1:0] fpc_q, fpc_d;
  logic [WL-1:0] req_addr_q;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count, used;
  logic          grant, push, pop, clr;
  ifq_entry_t    wentry, head;

  // The outstanding request holds a slot so a full queue can never be overrun.
  assign used        = count + CW'(inflight_q);
  assign bus.im_req  = RST && !bus.redirect && (used < CW'(DEPTH));
  assign bus.im_addr = fpc_q;
  assign grant       = bus.im_req && bus.im_gnt;

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = 1'b0;
    if (bus.redirect) begin
      fpc_d = bus.redirect_pc;
    end else if (grant) begin
      fpc_d      = fpc_q + 32'd1;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (grant) req_addr_q <= fpc_q;
  end

  // A response racing a redirect belongs to the old stream and is dropped.
  assign push   = RST && bus.im_rvalid && inflight_q && !bus.redirect;
  assign pop    = RST && bus.instr_valid && bus.dec_ready && !bus.redirect;
  assign clr    = !RST || bus.redirect;
  assign wentry = '{instr: bus.im_rdata, pcp1: req_addr_q + 32'd1};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = bus.instr_valid ? head.instr : NOP_INSTR;
  assign bus.pcp1        = bus.instr_valid ? head.pcp1  : '0;

`ifdef IFETCH_QUEUE_PERF_EN
  logic [WL-1:0] perf_fetched_q, perf_fetched_d;
  logic [WL-1:0] perf_flushed_q, perf_flushed_d;

  function automatic logic [WL-1:0] sat_add(input logic [WL-1:0] a, input logic [WL-1:0] b);
    logic [WL:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WL] ? '1 : s[WL-1:0];
  endfunction

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (push)         perf_fetched_d = sat_add(perf_fetched_q, 32'd1);
    if (bus.redirect) perf_flushed_d = sat_add(perf_flushed_q, WL'(count) + WL'(inflight_q));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases plus an in-order pop checker.
module tb_ifetch_queue;
  logic CLK = 1'b0;
  logic RST;
  logic spurious;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  ifetch_queue_if bus();

`ifdef IFETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
  ifetch_queue dut (.CLK(CLK), .RST(RST), .bus(bus),
                    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed));
`else
  ifetch_queue dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Instruction memory: answers exactly one cycle after each grant.
  initial begin
    logic        g, s;
    logic [31:0] a;
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = 32'h0;
    forever begin
      @(negedge CLK);
      g = bus.im_req && bus.im_gnt;
      a = bus.im_addr;
      s = spurious;
      @(posedge CLK);
      #1;
      bus.im_rvalid = g || s;
      bus.im_rdata  = g ? mem_fn(a) : 32'hDEAD_BEEF;
    end
  end

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_q.delete();
        exp_pc = 32'h0;
      end else begin
        if (bus.instr_valid && bus.dec_ready && !bus.redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_pop: got pcp1=%h expected no entry", bus.pcp1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_instr", bus.instr, mem_fn(e));
            chk("sb_pcp1", bus.pcp1, e + 32'd1);
          end
        end
        if (!bus.instr_valid) begin
          chk("idle_instr", bus.instr, 32'h0);
          chk("idle_pcp1", bus.pcp1, 32'h0);
        end
        if (bus.redirect) begin
          chk("redirect_req", {31'h0, bus.im_req}, 32'h0);
          exp_q.delete();
          exp_pc = bus.redirect_pc;
        end else if (bus.im_req && bus.im_gnt) begin
          chk("sb_addr", bus.im_addr, exp_pc);
          exp_q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd1;
        end
      end
    end
  endtask

  initial begin
    RST = 1'b0; spurious = 1'b0;
    bus.im_gnt = 1'b0; bus.dec_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    fork monitor(); join_none

    // Reset state
    repeat (3) tick();
    @(negedge CLK);
    chk("rst_req", {31'h0, bus.im_req}, 32'h0);
    chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pcp1", bus.pcp1, 32'h0);
    chk("rst_addr", bus.im_addr, 32'h0);

    // Streaming at one instruction per cycle
    tick(); RST = 1'b1; bus.im_gnt = 1'b1; bus.dec_ready = 1'b1;
    @(negedge CLK);
    chk("c0_addr", bus.im_addr, 32'h0);
    chk("c0_req", {31'h0, bus.im_req}, 32'h1);
    chk("c0_valid", {31'h0, bus.instr_valid}, 32'h0);
    tick();
    @(negedge CLK);
    chk("c1_addr", bus.im_addr, 32'h1);
    chk("c1_valid", {31'h0, bus.instr_valid}, 32'h0);
    tick();
    @(negedge CLK);
    chk("c2_valid", {31'h0, bus.instr_valid}, 32'h1);
    chk("c2_instr", bus.instr, mem_fn(32'h0));
    chk("c2_pcp1", bus.pcp1, 32'h1);
    chk("c2_addr", bus.im_addr, 32'h2);
    repeat (8) tick();

    // Stall for 10 cycles: queue fills to DEPTH and requests stop
    bus.dec_ready = 1'b0;
    repeat (9) tick();
    @(negedge CLK);
    chk("stall_req", {31'h0, bus.im_req}, 32'h0);
    chk("stall_addr", bus.im_addr, 32'hC);
    chk("stall_instr", bus.instr, mem_fn(32'h8));
    chk("stall_pcp1", bus.pcp1, 32'h9);
    tick(); bus.dec_ready = 1'b1;
    repeat (8) tick();

    // Redirect with 3 queued and 1 in flight
    bus.dec_ready = 1'b0;
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    @(negedge CLK);
    chk("pre_redir_valid", {31'h0, bus.instr_valid}, 32'h1);
    chk("pre_redir_req", {31'h0, bus.im_req}, 32'h0);
    tick(); bus.redirect = 1'b0; bus.dec_ready = 1'b1;
    @(negedge CLK);
    chk("redir_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("redir_addr", bus.im_addr, 32'h40);
    chk("redir_req", {31'h0, bus.im_req}, 32'h1);
`ifdef IFETCH_QUEUE_PERF_EN
    chk("perf_flushed", perf_flushed, 32'h4);
`endif
    tick();
    @(negedge CLK);
    chk("redir1_valid", {31'h0, bus.instr_valid}, 32'h0);
    tick();
    @(negedge CLK);
    chk("redir2_instr", bus.instr, mem_fn(32'h40));
    chk("redir2_pcp1", bus.pcp1, 32'h41);

    // Grant toggling
    for (int i = 0; i < 12; i++) begin
      tick(); bus.im_gnt = i[0];
    end
    tick(); bus.im_gnt = 1'b1;
    repeat (4) tick();

    // Address wrap at 2^32-1
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    tick(); bus.redirect = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    chk("wrap_addr", bus.im_addr, 32'h0);
    chk("wrap_pcp1_a", bus.pcp1, 32'hFFFF_FFFF);
    tick();
    @(negedge CLK);
    chk("wrap_pcp1_b", bus.pcp1, 32'h0);
    chk("wrap_instr_b", bus.instr, mem_fn(32'hFFFF_FFFF));
    repeat (4) tick();

    // Reset mid-stream together with redirect; stray response afterwards
    tick(); RST = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h80; spurious = 1'b1;
    @(negedge CLK);
    chk("mrst_req", {31'h0, bus.im_req}, 32'h0);
    tick(); RST = 1'b1; bus.redirect = 1'b0; spurious = 1'b0;
    @(negedge CLK);
    chk("mrst_addr", bus.im_addr, 32'h0);
    chk("mrst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("mrst_req1", {31'h0, bus.im_req}, 32'h1);
`ifdef IFETCH_QUEUE_PERF_EN
    chk("mrst_perf_fetched", perf_fetched, 32'h0);
    chk("mrst_perf_flushed", perf_flushed, 32'h0);
`endif
    tick();
    @(negedge CLK);
    chk("stray_valid", {31'h0, bus.instr_valid}, 32'h0);
`ifdef IFETCH_QUEUE_PERF_EN
    chk("stray_perf_fetched", perf_fetched, 32'h0);
`endif
    tick();
    @(negedge CLK);
    chk("mrst_instr", bus.instr, mem_fn(32'h0));
    chk("mrst_pcp1", bus.pcp1, 32'h1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
